// File: rtl/aes_uart_cmd_rx.sv
// aes_uart_cmd_rx: UART command-frame receiver for the AES-128 demo.
//
// Receives A5 <mode> <16 key bytes> <16 data bytes> over 8N1 UART and
// presents {enc/dec, key, data} through a valid/ready handshake.
// Define AES_RX_CHECKSUM_EN to require a trailing XOR checksum byte
// computed over the mode, key and data bytes.
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   uart_rxd               raw serial input (idle high, asynchronous)
//   cmd_valid, cmd_ready   frame handshake
//   cmd_enc_dec            1 = encrypt, 0 = decrypt
//   cmd_key, cmd_data      first received byte in [127:120]
//   err_framing/cmd/timeout/overrun   one-cycle error pulses
//   rx_busy                frame assembly in progress
module aes_uart_cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT_CLKS = 17360,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         uart_rxd,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic         cmd_enc_dec,
    output logic [127:0] cmd_key,
    output logic [127:0] cmd_data,
    output logic         err_framing,
    output logic         err_cmd,
    output logic         err_timeout,
    output logic         err_overrun,
    output logic         rx_busy
);
    localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
    localparam int unsigned   TW        = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_e;
    typedef enum logic [2:0] {F_HUNT, F_MODE, F_KEY, F_DATA, F_CHK} frame_state_e;

    logic           rxd_meta_q, rxd_q, rxd_prev_q;
    bit_state_e     bs_q, bs_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     sh_q, sh_d;
    frame_state_e   fs_q, fs_d;
    logic [3:0]     idx_q, idx_d;
    logic [127:0]   key_sh_q, key_sh_d, dat_sh_q, dat_sh_d;
    logic           enc_sh_q, enc_sh_d;
    logic [TW-1:0]  idle_q, idle_d;
`ifdef AES_RX_CHECKSUM_EN
    logic [7:0]     chk_q, chk_d;
`endif
    logic           cmd_valid_q, cmd_valid_d, cmd_enc_q, cmd_enc_d;
    logic [127:0]   cmd_key_q, cmd_key_d, cmd_data_q, cmd_data_d;
    logic           err_fe_q, err_fe_d, err_cmd_q, err_cmd_d;
    logic           err_to_q, err_to_d, err_ov_q, err_ov_d;
    logic           byte_stb, frame_err, publish, bad_cmd, tmo, load;

    // Stop-bit sample: a high line yields the byte strobe, a low line a framing error.
    assign byte_stb  = (bs_q == B_STOP) && (cnt_q == '0) && rxd_q;
    assign frame_err = (bs_q == B_STOP) && (cnt_q == '0) && !rxd_q;

    always_comb begin
        bs_d      = bs_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        case (bs_q)
            // Arming needs a 1->0 edge, so a line still low after a bad stop bit waits for high.
            B_IDLE: if (rxd_prev_q && !rxd_q) begin
                bs_d  = B_START;
                cnt_d = HALF_BIT;
            end
            B_START: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else if (rxd_q) bs_d = B_IDLE;
                else begin
                    bs_d      = B_DATA;
                    cnt_d     = FULL_BIT;
                    bit_idx_d = '0;
                end
            B_DATA: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else begin
                    sh_d      = {rxd_q, sh_q[7:1]};
                    cnt_d     = FULL_BIT;
                    bit_idx_d = bit_idx_q + 3'd1;
                    bs_d      = (bit_idx_q == 3'd7) ? B_STOP : B_DATA;
                end
            B_STOP: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else bs_d = B_IDLE;
            default: bs_d = B_IDLE;
        endcase
    end

    always_comb begin
        fs_d     = fs_q;
        idx_d    = idx_q;
        key_sh_d = key_sh_q;
        dat_sh_d = dat_sh_q;
        enc_sh_d = enc_sh_q;
`ifdef AES_RX_CHECKSUM_EN
        chk_d    = chk_q;
`endif
        publish  = 1'b0;
        bad_cmd  = 1'b0;
        // Idle time only accrues between bytes, never while a byte is being shifted in.
        idle_d   = (fs_q == F_HUNT || byte_stb) ? '0 : (bs_q == B_IDLE) ? idle_q + 1'b1 : idle_q;
        tmo      = (fs_q != F_HUNT) && (idle_q == TMO_LIMIT);
        if (byte_stb) begin
            case (fs_q)
                F_HUNT: if (sh_q == SYNC_BYTE) fs_d = F_MODE;
                F_MODE: begin
                    idx_d = '0;
`ifdef AES_RX_CHECKSUM_EN
                    chk_d = sh_q;
`endif
                    if (sh_q[7:1] == 7'd0) begin
                        enc_sh_d = sh_q[0];
                        fs_d     = F_KEY;
                    end else begin
                        bad_cmd = 1'b1;
                        fs_d    = F_HUNT;
                    end
                end
                F_KEY: begin
                    key_sh_d = {key_sh_q[119:0], sh_q};
                    idx_d    = idx_q + 4'd1;
`ifdef AES_RX_CHECKSUM_EN
                    chk_d    = chk_q ^ sh_q;
`endif
                    if (idx_q == 4'd15) fs_d = F_DATA;
                end
                F_DATA: begin
                    dat_sh_d = {dat_sh_q[119:0], sh_q};
                    idx_d    = idx_q + 4'd1;
`ifdef AES_RX_CHECKSUM_EN
                    chk_d    = chk_q ^ sh_q;
                    if (idx_q == 4'd15) fs_d = F_CHK;
`else
                    if (idx_q == 4'd15) begin
                        fs_d    = F_HUNT;
                        publish = 1'b1;
                    end
`endif
                end
`ifdef AES_RX_CHECKSUM_EN
                F_CHK: begin
                    fs_d    = F_HUNT;
                    publish = (sh_q == chk_q);
                    bad_cmd = (sh_q != chk_q);
                end
`endif
                default: fs_d = F_HUNT;
            endcase
        end
        if (tmo || (frame_err && fs_q != F_HUNT)) fs_d = F_HUNT;
    end

    // Holding is tracked by cmd_valid_q alone so that reception keeps running meanwhile.
    always_comb begin
        load        = publish && (!cmd_valid_q || cmd_ready);
        cmd_valid_d = load || (cmd_valid_q && !cmd_ready);
        cmd_enc_d   = load ? enc_sh_q : cmd_enc_q;
        cmd_key_d   = load ? key_sh_q : cmd_key_q;
        cmd_data_d  = load ? dat_sh_d : cmd_data_q;
        err_fe_d    = frame_err;
        err_to_d    = tmo && !frame_err;
        err_cmd_d   = bad_cmd && !frame_err && !tmo;
        err_ov_d    = publish && !load && !frame_err && !tmo && !bad_cmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q  <= 1'b1;
            rxd_q       <= 1'b1;
            rxd_prev_q  <= 1'b1;
            bs_q        <= B_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            sh_q        <= '0;
            fs_q        <= F_HUNT;
            idx_q       <= '0;
            key_sh_q    <= '0;
            dat_sh_q    <= '0;
            enc_sh_q    <= 1'b0;
            idle_q      <= '0;
`ifdef AES_RX_CHECKSUM_EN
            chk_q       <= '0;
`endif
            cmd_valid_q <= 1'b0;
            cmd_enc_q   <= 1'b0;
            cmd_key_q   <= '0;
            cmd_data_q  <= '0;
            err_fe_q    <= 1'b0;
            err_cmd_q   <= 1'b0;
            err_to_q    <= 1'b0;
            err_ov_q    <= 1'b0;
        end else begin
            rxd_meta_q  <= uart_rxd;
            rxd_q       <= rxd_meta_q;
            rxd_prev_q  <= rxd_q;
            bs_q        <= bs_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            sh_q        <= sh_d;
            fs_q        <= fs_d;
            idx_q       <= idx_d;
            key_sh_q    <= key_sh_d;
            dat_sh_q    <= dat_sh_d;
            enc_sh_q    <= enc_sh_d;
            idle_q      <= idle_d;
`ifdef AES_RX_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
            cmd_valid_q <= cmd_valid_d;
            cmd_enc_q   <= cmd_enc_d;
            cmd_key_q   <= cmd_key_d;
            cmd_data_q  <= cmd_data_d;
            err_fe_q    <= err_fe_d;
            err_cmd_q   <= err_cmd_d;
            err_to_q    <= err_to_d;
            err_ov_q    <= err_ov_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_enc_dec = cmd_enc_q;
    assign cmd_key     = cmd_key_q;
    assign cmd_data    = cmd_data_q;
    assign err_framing = err_fe_q;
    assign err_cmd     = err_cmd_q;
    assign err_timeout = err_to_q;
    assign err_overrun = err_ov_q;
    assign rx_busy     = (fs_q != F_HUNT);
endmodule

// File: doc/aes_uart_cmd_rx.md
Name: aes_uart_cmd_rx

Overview:
- Host-to-board input path for the AES-128 Canright demo: the counterpart of the switch/7-segment result path.
- Receives a UART byte stream from the board USB-UART bridge and assembles a command frame: sync, mode, 128-bit key, 128-bit data.
- Presents the frame to the AES core control logic through a valid/ready handshake.
- Replaces hard-coded test vectors with host-supplied operands.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); must be >= 4.
- TIMEOUT_CLKS, 17360, max idle clk cycles between bytes inside a frame before abort (about 2 byte times).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- uart_rxd  in  1  raw serial input, idle high, asynchronous to clk
- cmd_valid  out  1  frame held on outputs, awaiting acceptance
- cmd_ready  in  1  consumer accepts frame when high with cmd_valid
- cmd_enc_dec  out  1  1 = encrypt, 0 = decrypt
- cmd_key  out  128  key, first received key byte in [127:120]
- cmd_data  out  128  plaintext/ciphertext, first received data byte in [127:120]
- err_framing  out  1  one-cycle pulse: stop bit sampled 0
- err_cmd  out  1  one-cycle pulse: bad mode byte (or bad checksum)
- err_timeout  out  1  one-cycle pulse: inter-byte timeout mid-frame
- err_overrun  out  1  one-cycle pulse: complete frame dropped because cmd_valid was still high
- rx_busy  out  1  frame assembly in progress (state not HUNT)

Behaviour:
- Reset: all outputs 0; cmd_key and cmd_data 0; both FSMs idle.
  - Reset is asynchronous and may occur mid-byte or mid-frame; the partial frame is discarded.

Bit-level receiver:
- Input path: uart_rxd passes through a 2-flop synchronizer, reset value 1.
- IDLE: a sampled 1->0 transition enters START; the counter loads CLKS_PER_BIT/2 (integer division).
- START: at counter expiry, re-sample the line.
  - Line 0: go to DATA.
  - Line 1: false start; return to IDLE with no error.
- DATA: 8 samples spaced CLKS_PER_BIT, LSB first.
- STOP: one sample CLKS_PER_BIT later.
  - Line 1: one-cycle internal byte strobe.
  - Line 0: err_framing pulse, no strobe.
  - Either way return to IDLE, which waits for the line to be high before arming again.

Frame FSM (states HUNT, MODE, KEY, DATA, HOLD):
- HUNT: bytes other than SYNC_BYTE are silently ignored; SYNC_BYTE goes to MODE.
- MODE:
  - 0x01 sets enc=1; 0x00 sets enc=0.
  - Any other value: err_cmd pulse, go to HUNT.
- KEY: 16 bytes shifted into a key shadow register, MSB first; byte index 0..15; go to DATA after index 15.
- DATA: 16 bytes into the data shadow register, same rule.
  - On the 16th byte: copy the shadows to the cmd_* outputs and assert cmd_valid on the next clk edge.
  - Latency: cmd_valid rises exactly 1 cycle after the final byte's stop-bit sample.
- HOLD:
  - cmd_valid and the cmd_* outputs are stable.
  - On the cycle where cmd_valid && cmd_ready, cmd_valid drops the next cycle.
  - cmd_valid must never drop without acceptance.
- Reception continues during HOLD; the FSM keeps hunting and assembling into the shadow registers only.
  - A frame that completes while cmd_valid is still high: err_overrun pulse, frame discarded, held frame untouched.
  - If acceptance and completion occur in the same cycle: the new frame is loaded and cmd_valid stays high; no overrun.
- Timeout:
  - An idle counter runs while state is in MODE/KEY/DATA and the byte receiver is IDLE; it clears on every byte strobe.
  - Reaching TIMEOUT_CLKS: err_timeout pulse, shadow discarded, go to HUNT.
- Framing error in MODE/KEY/DATA: also aborts to HUNT, in addition to the err_framing pulse.
- Error pulses are mutually exclusive per cycle; priority framing > timeout > cmd > overrun.

Optional Feature:
- AES_RX_CHECKSUM_EN defined:
  - A 35th byte (CHK state after DATA) must equal the XOR of the mode, key and data bytes (sync excluded).
  - Match: frame published as above, latency measured from the checksum byte.
  - Mismatch: err_cmd pulse, frame discarded, go to HUNT.
- Undefined: no CHK state; the frame is 34 bytes and publishes after the 16th data byte.

Test Plan:
- NIST C.1 encrypt: send A5 01, key bytes 00..0F, data bytes 00 11 22 .. FF, with cmd_ready=1 -> cmd_valid for 1 cycle, cmd_enc_dec=1, cmd_key=000102030405060708090a0b0c0d0e0f, cmd_data=00112233445566778899aabbccddeeff, no error pulses.
- Noise and bad mode:
  - Send 3C 7E before a FIPS-197 App. B decrypt frame (A5 00, key 2b7e1516..4f3c, data 3925841d..0b32) -> leading bytes ignored, frame accepted with cmd_enc_dec=0.
  - Mode byte 0x07 -> err_cmd, no cmd_valid.
- Framing error: force the stop bit low on key byte 5 -> err_framing, rx_busy falls; an immediately following valid frame is received correctly.
- Timeout: send A5 01 and 3 key bytes, hold the line high for TIMEOUT_CLKS+10 cycles -> err_timeout, rx_busy=0; the next full frame is accepted.
- Backpressure: cmd_ready=0, send frame A then frame B -> cmd_valid and A's values held throughout, err_overrun after B completes; raise cmd_ready -> cmd_valid drops the next cycle with A's values still shown.
- Reset and false start:
  - Assert rst_n low mid key byte 10 -> all outputs 0; after release, a full frame decodes correctly.
  - A 1-bit-time-minus low glitch on idle uart_rxd shorter than CLKS_PER_BIT/2 -> no strobe, no error.
